// File: rtl/ball_sprite_mixer.sv
// rtl/ball_sprite_mixer.sv - bouncing square ball mixed over the background pixel stream
//
// Ports:
//   clk_i, rst_ni            pixel clock, asynchronous active-low reset
//   enable_i                 motion enable (0 freezes the ball)
//   hpos_i, vpos_i           raster position
//   display_on_i, hsync_i,
//   vsync_i, rgb_i           timing flags and background colour from upstream
//   rgb_o, hsync_o, vsync_o,
//   display_on_o             mixed colour and flags, all one register stage late
//   ball_x_o, ball_y_o       current ball top-left corner
//   bounce_o                 one-cycle pulse after a frame tick that hit an edge
module ball_sprite_mixer #(
    parameter int          H_DISPLAY  = 256,
    parameter int          V_DISPLAY  = 240,
    parameter int          BALL_SIZE  = 4,
    parameter int          SPEED      = 1,
    parameter int          INIT_X     = 128,
    parameter int          INIT_Y     = 128,
    parameter logic [23:0] BALL_COLOR = 24'hFFFFFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic [8:0]  hpos_i,
    input  logic [8:0]  vpos_i,
    input  logic        display_on_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic [23:0] rgb_i,
    output logic [23:0] rgb_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        display_on_o,
    output logic [8:0]  ball_x_o,
    output logic [8:0]  ball_y_o,
    output logic        bounce_o
);

    localparam logic [9:0] X_LIM  = 10'(H_DISPLAY - BALL_SIZE);
    localparam logic [9:0] Y_LIM  = 10'(V_DISPLAY - BALL_SIZE);
    localparam logic [9:0] SPD    = 10'(SPEED);
    localparam logic [8:0] SPD9   = 9'(SPEED);
    localparam logic [9:0] BSZ    = 10'(BALL_SIZE);
    localparam logic [8:0] INIT_X9 = 9'(INIT_X);
    localparam logic [8:0] INIT_Y9 = 9'(INIT_Y);

    logic [8:0] ball_x, ball_y;
    logic       x_left, y_up;     // 1 = moving towards zero on that axis
    logic       vsync_prev;

    logic [8:0] x_next, y_next;
    logic       x_left_next, y_up_next;
    logic       bounce_x, bounce_y;
    logic [9:0] x_sum, y_sum;
    logic [9:0] dx, dy;
    logic       tick, hit;

    // Frame tick on the rising edge of vsync_i; vsync_prev resets high so a
    // vsync already high at reset release does not count as a frame start.
    assign tick = vsync_i & ~vsync_prev;

    always_comb begin
        x_sum       = {1'b0, ball_x} + SPD;
        y_sum       = {1'b0, ball_y} + SPD;
        x_next      = ball_x;
        y_next      = ball_y;
        x_left_next = x_left;
        y_up_next   = y_up;
        bounce_x    = 1'b0;
        bounce_y    = 1'b0;

        // Edges clamp rather than overshoot, so the ball never wraps.
        if (!x_left) begin
            if (x_sum >= X_LIM) begin
                x_next      = X_LIM[8:0];
                x_left_next = 1'b1;
                bounce_x    = 1'b1;
            end else begin
                x_next = x_sum[8:0];
            end
        end else if ({1'b0, ball_x} <= SPD) begin
            x_next      = 9'd0;
            x_left_next = 1'b0;
            bounce_x    = 1'b1;
        end else begin
            x_next = ball_x - SPD9;
        end

        if (!y_up) begin
            if (y_sum >= Y_LIM) begin
                y_next    = Y_LIM[8:0];
                y_up_next = 1'b1;
                bounce_y  = 1'b1;
            end else begin
                y_next = y_sum[8:0];
            end
        end else if ({1'b0, ball_y} <= SPD) begin
            y_next    = 9'd0;
            y_up_next = 1'b0;
            bounce_y  = 1'b1;
        end else begin
            y_next = ball_y - SPD9;
        end
    end

    // A raster position left of / above the ball underflows to a large value
    // in the 10-bit difference and therefore misses.
    always_comb begin
        dx  = {1'b0, hpos_i} - {1'b0, ball_x};
        dy  = {1'b0, vpos_i} - {1'b0, ball_y};
        hit = display_on_i && (dx < BSZ) && (dy < BSZ);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ball_x       <= INIT_X9;
            ball_y       <= INIT_Y9;
            x_left       <= 1'b0;
            y_up         <= 1'b0;
            vsync_prev   <= 1'b1;
            rgb_o        <= 24'h000000;
            hsync_o      <= 1'b0;
            vsync_o      <= 1'b0;
            display_on_o <= 1'b0;
            bounce_o     <= 1'b0;
        end else begin
            vsync_prev   <= vsync_i;
            hsync_o      <= hsync_i;
            vsync_o      <= vsync_i;
            display_on_o <= display_on_i;
            rgb_o        <= !display_on_i ? 24'h000000 : (hit ? BALL_COLOR : rgb_i);
            bounce_o     <= tick & enable_i & (bounce_x | bounce_y);
            if (tick && enable_i) begin
                ball_x <= x_next;
                ball_y <= y_next;
                x_left <= x_left_next;
                y_up   <= y_up_next;
            end
        end
    end

    assign ball_x_o = ball_x;
    assign ball_y_o = ball_y;

endmodule

// File: tb/tb_ball_sprite_mixer.sv
// tb/tb_ball_sprite_mixer.sv - randomized model-checked bench for ball_sprite_mixer
module tb_ball_sprite_mixer;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        enable_i;
    logic [8:0]  hpos_i, vpos_i;
    logic        display_on_i, hsync_i, vsync_i;
    logic [23:0] rgb_i;

    logic [23:0] rgb_o        [3];
    logic        hsync_o      [3];
    logic        vsync_o      [3];
    logic        display_on_o [3];
    logic [8:0]  ball_x_o     [3];
    logic [8:0]  ball_y_o     [3];
    logic        bounce_o     [3];

    localparam int          P_H   [3] = '{256, 256, 15};
    localparam int          P_V   [3] = '{240, 240, 15};
    localparam int          P_BS  [3] = '{4, 4, 4};
    localparam int          P_SP  [3] = '{1, 2, 2};
    localparam int          P_IX  [3] = '{128, 250, 9};
    localparam int          P_IY  [3] = '{128, 128, 9};
    localparam logic [23:0] P_COL [3] = '{24'hFFFFFF, 24'hFF0000, 24'h123456};

    always #5 clk = ~clk;

    ball_sprite_mixer #(.H_DISPLAY(256), .V_DISPLAY(240), .BALL_SIZE(4), .SPEED(1),
        .INIT_X(128), .INIT_Y(128), .BALL_COLOR(24'hFFFFFF)) u0 (
        .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .hpos_i(hpos_i), .vpos_i(vpos_i),
        .display_on_i(display_on_i), .hsync_i(hsync_i), .vsync_i(vsync_i), .rgb_i(rgb_i),
        .rgb_o(rgb_o[0]), .hsync_o(hsync_o[0]), .vsync_o(vsync_o[0]),
        .display_on_o(display_on_o[0]), .ball_x_o(ball_x_o[0]), .ball_y_o(ball_y_o[0]),
        .bounce_o(bounce_o[0]));

    ball_sprite_mixer #(.H_DISPLAY(256), .V_DISPLAY(240), .BALL_SIZE(4), .SPEED(2),
        .INIT_X(250), .INIT_Y(128), .BALL_COLOR(24'hFF0000)) u1 (
        .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .hpos_i(hpos_i), .vpos_i(vpos_i),
        .display_on_i(display_on_i), .hsync_i(hsync_i), .vsync_i(vsync_i), .rgb_i(rgb_i),
        .rgb_o(rgb_o[1]), .hsync_o(hsync_o[1]), .vsync_o(vsync_o[1]),
        .display_on_o(display_on_o[1]), .ball_x_o(ball_x_o[1]), .ball_y_o(ball_y_o[1]),
        .bounce_o(bounce_o[1]));

    ball_sprite_mixer #(.H_DISPLAY(15), .V_DISPLAY(15), .BALL_SIZE(4), .SPEED(2),
        .INIT_X(9), .INIT_Y(9), .BALL_COLOR(24'h123456)) u2 (
        .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .hpos_i(hpos_i), .vpos_i(vpos_i),
        .display_on_i(display_on_i), .hsync_i(hsync_i), .vsync_i(vsync_i), .rgb_i(rgb_i),
        .rgb_o(rgb_o[2]), .hsync_o(hsync_o[2]), .vsync_o(vsync_o[2]),
        .display_on_o(display_on_o[2]), .ball_x_o(ball_x_o[2]), .ball_y_o(ball_y_o[2]),
        .bounce_o(bounce_o[2]));

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: positions as signed integers with a +1/-1 heading.
    int          mx [3], my [3], mdx [3], mdy [3];
    logic [23:0] e_rgb [3];
    bit          e_bounce [3];
    bit          e_hs, e_vs, e_de, m_vprev;

    function automatic void step_axis(input int p, input int d, input int lim, input int sp,
                                      output int np, output int nd, output bit b);
        np = p + d * sp;
        nd = d;
        b  = 1'b0;
        if (d > 0 && np >= lim) begin
            np = lim; nd = -1; b = 1'b1;
        end else if (d < 0 && np <= 0) begin
            np = 0; nd = 1; b = 1'b1;
        end
    endfunction

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 3; i++) begin
                mx[i] <= P_IX[i]; my[i] <= P_IY[i];
                mdx[i] <= 1; mdy[i] <= 1;
                e_rgb[i] <= 24'h0; e_bounce[i] <= 1'b0;
            end
            e_hs <= 1'b0; e_vs <= 1'b0; e_de <= 1'b0; m_vprev <= 1'b1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                int  nx, ny, ndx, ndy;
                bit  bx, by, in_x, in_y;
                in_x = int'(hpos_i) >= mx[i] && int'(hpos_i) < mx[i] + P_BS[i];
                in_y = int'(vpos_i) >= my[i] && int'(vpos_i) < my[i] + P_BS[i];
                e_rgb[i] <= !display_on_i ? 24'h0 : ((in_x && in_y) ? P_COL[i] : rgb_i);
                if (vsync_i && !m_vprev && enable_i) begin
                    step_axis(mx[i], mdx[i], P_H[i] - P_BS[i], P_SP[i], nx, ndx, bx);
                    step_axis(my[i], mdy[i], P_V[i] - P_BS[i], P_SP[i], ny, ndy, by);
                    mx[i] <= nx; mdx[i] <= ndx; my[i] <= ny; mdy[i] <= ndy;
                    e_bounce[i] <= bx || by;
                end else begin
                    e_bounce[i] <= 1'b0;
                end
            end
            e_hs <= hsync_i; e_vs <= vsync_i; e_de <= display_on_i; m_vprev <= vsync_i;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("rgb[%0d]", i), 32'(rgb_o[i]), 32'(e_rgb[i]));
                chk($sformatf("hsync[%0d]", i), 32'(hsync_o[i]), 32'(e_hs));
                chk($sformatf("vsync[%0d]", i), 32'(vsync_o[i]), 32'(e_vs));
                chk($sformatf("de[%0d]", i), 32'(display_on_o[i]), 32'(e_de));
                chk($sformatf("x[%0d]", i), 32'(ball_x_o[i]), 32'(mx[i]));
                chk($sformatf("y[%0d]", i), 32'(ball_y_o[i]), 32'(my[i]));
                chk($sformatf("bounce[%0d]", i), 32'(bounce_o[i]), 32'(e_bounce[i]));
            end
        end
    end

    task automatic do_tick();
        vsync_i = 1'b0;
        @(negedge clk);
        vsync_i = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int snap_x, snap_y;
        rst_ni = 1'b0; enable_i = 1'b1; hpos_i = '0; vpos_i = '0;
        display_on_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b1; rgb_i = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_rgb", 32'(rgb_o[0]), 32'h0);
        chk("reset_x", 32'(ball_x_o[0]), 32'd128);
        chk("reset_bounce", 32'(bounce_o[0]), 32'd0);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_tick_at_release", 32'(ball_x_o[0]), 32'd128);

        display_on_i = 1'b1; rgb_i = 24'h00FF00; hpos_i = 9'd131; vpos_i = 9'd128;
        @(negedge clk); chk("hit_131", 32'(rgb_o[0]), 32'hFFFFFF);
        hpos_i = 9'd132;
        @(negedge clk); chk("miss_132", 32'(rgb_o[0]), 32'h00FF00);
        hpos_i = 9'd127;
        @(negedge clk); chk("miss_127", 32'(rgb_o[0]), 32'h00FF00);
        hpos_i = 9'd130; display_on_i = 1'b0;
        @(negedge clk); chk("blank", 32'(rgb_o[0]), 32'h000000);

        do_tick();
        chk("t1_x0", 32'(ball_x_o[0]), 32'd129);
        chk("t1_y0", 32'(ball_y_o[0]), 32'd129);
        chk("t1_b0", 32'(bounce_o[0]), 32'd0);
        chk("t1_x1", 32'(ball_x_o[1]), 32'd252);
        chk("t1_b1", 32'(bounce_o[1]), 32'd1);
        @(negedge clk);
        chk("t1_b1_end", 32'(bounce_o[1]), 32'd0);
        repeat (100) @(negedge clk);
        chk("vsync_held", 32'(ball_x_o[0]), 32'd129);
        do_tick();
        chk("t2_x1", 32'(ball_x_o[1]), 32'd250);
        do_tick();
        chk("t3_x1", 32'(ball_x_o[1]), 32'd248);
        chk("t3_x2", 32'(ball_x_o[2]), 32'd7);
        repeat (3) do_tick();
        chk("t6_x2", 32'(ball_x_o[2]), 32'd1);
        do_tick();
        chk("corner_x", 32'(ball_x_o[2]), 32'd0);
        chk("corner_y", 32'(ball_y_o[2]), 32'd0);
        chk("corner_b", 32'(bounce_o[2]), 32'd1);
        @(negedge clk);
        chk("corner_b_end", 32'(bounce_o[2]), 32'd0);
        do_tick();
        chk("after_corner_x", 32'(ball_x_o[2]), 32'd2);
        chk("after_corner_y", 32'(ball_y_o[2]), 32'd2);

        for (int c = 0; c < 4000; c++) begin
            int k;
            k = $urandom_range(0, 2);
            hpos_i = 9'(mx[k] + $urandom_range(0, 7) - 2);
            vpos_i = 9'(my[k] + $urandom_range(0, 7) - 2);
            if ($urandom_range(0, 9) == 0) hpos_i = 9'($urandom_range(0, 511));
            display_on_i = ($urandom_range(0, 4) != 0);
            hsync_i = 1'($urandom_range(0, 1));
            vsync_i = ($urandom_range(0, 5) == 0);
            enable_i = ($urandom_range(0, 9) != 0);
            rgb_i = 24'($urandom);
            @(negedge clk);
        end

        enable_i = 1'b1; vsync_i = 1'b1;
        @(negedge clk);
        enable_i = 1'b0;
        snap_x = mx[2]; snap_y = my[2];
        for (int t = 0; t < 3; t++) begin
            do_tick();
            chk("frozen_bounce", 32'(bounce_o[2]), 32'd0);
        end
        chk("frozen_x", 32'(ball_x_o[2]), 32'(snap_x));
        chk("frozen_y", 32'(ball_y_o[2]), 32'(snap_y));

        enable_i = 1'b1; display_on_i = 1'b1; rgb_i = 24'h0000FF; hpos_i = 9'd400;
        @(negedge clk);
        chk("pre_reset_rgb", 32'(rgb_o[0]), 32'h0000FF);
        #2 rst_ni = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("midreset_rgb", 32'(rgb_o[i]), 32'h0);
            chk("midreset_x", 32'(ball_x_o[i]), 32'(P_IX[i]));
            chk("midreset_y", 32'(ball_y_o[i]), 32'(P_IY[i]));
        end
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
